// File: rtl/ahb_mem_responder.sv
// Read-only AHB-style memory responder for an LCD DMA master: bus grant handshake,
// programmable read wait states, two-cycle ERROR response and a backdoor preload port.
module ahb_mem_responder #(
  parameter int unsigned WAIT_STATES = 1,
  parameter logic [31:0] BASE        = 32'h0000_0000
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        mHBUSREQ,
  output logic        mHGRANT,
  input  logic [1:0]  mHTRANS,
  input  logic [31:0] mHADDR,
  input  logic        mHWRITE,
  input  logic [2:0]  mHSIZE,
  input  logic [2:0]  mHBURST,
  output logic        mHREADY,
  output logic [1:0]  mHRESP,
  output logic [31:0] mHRDATA,
  input  logic        ld_we,
  input  logic [7:0]  ld_addr,
  input  logic [31:0] ld_data
);

  typedef enum logic {G_IDLE = 1'b0, G_OWN = 1'b1} g_state_e;
  typedef enum logic [2:0] {
    D_IDLE = 3'd0,
    D_WAIT = 3'd1,
    D_DATA = 3'd2,
    D_ERR1 = 3'd3,
    D_ERR2 = 3'd4
  } d_state_e;

  localparam logic [1:0] HTRANS_SEQ = 2'b11;
  localparam logic [2:0] HSIZE_WORD = 3'b010;
  localparam logic [1:0] HRESP_OKAY = 2'b00;
  localparam logic [1:0] HRESP_ERR  = 2'b01;
  // Wait counter counts down to zero, so it is loaded with one less than the wait length.
  localparam logic [3:0] WS_LOAD = (WAIT_STATES == 32'd0) ? 4'd0 : 4'(WAIT_STATES - 32'd1);

  g_state_e    g_state_q, g_state_d;
  d_state_e    d_state_q, d_state_d;
  logic [3:0]  wcnt_q, wcnt_d;
  logic [7:0]  idx_q, idx_d;
  logic [31:0] prev_q, prev_d;
  logic [31:0] rdata_q;
  logic        ready_q, ready_d;
  logic [1:0]  resp_q, resp_d;
  logic        rd_load_s;
  logic [7:0]  rd_idx_s;
  logic        accept_s;
  logic        err_s;
  logic        unused_s;
  logic [31:0] mem_q [256];

  assign unused_s = ^mHBURST;
  assign mHGRANT  = (g_state_q == G_OWN);
  assign mHREADY  = ready_q;
  assign mHRESP   = resp_q;
  assign mHRDATA  = rdata_q;

  // An address phase presented while the ERROR tail is finishing is dropped on purpose.
  assign accept_s = ready_q & mHGRANT & (d_state_q != D_ERR2) & mHTRANS[1];

  assign err_s = mHWRITE
              | (mHSIZE != HSIZE_WORD)
              | (mHADDR[1:0] != 2'b00)
              | (mHADDR[31:10] != BASE[31:10])
              | ((mHTRANS == HTRANS_SEQ) & (mHADDR != (prev_q + 32'd4)));

  // Grant next-state: ownership is only released once no data phase is outstanding.
  always_comb begin
    g_state_d = g_state_q;
    case (g_state_q)
      G_IDLE: begin
        if (mHBUSREQ) begin
          g_state_d = G_OWN;
        end else begin
          g_state_d = G_IDLE;
        end
      end
      G_OWN: begin
        if (!mHBUSREQ && (d_state_q == D_IDLE)) begin
          g_state_d = G_IDLE;
        end else begin
          g_state_d = G_OWN;
        end
      end
      default: g_state_d = G_IDLE;
    endcase
  end

  // Data-phase next-state, wait counter, captured address and read-data load strobe.
  always_comb begin
    d_state_d = d_state_q;
    wcnt_d    = wcnt_q;
    idx_d     = idx_q;
    prev_d    = prev_q;
    rd_load_s = 1'b0;
    rd_idx_s  = idx_q;
    case (d_state_q)
      D_IDLE, D_DATA: begin
        if (accept_s) begin
          if (err_s) begin
            d_state_d = D_ERR1;
          end else begin
            prev_d = mHADDR;
            idx_d  = mHADDR[9:2];
            if (WAIT_STATES == 32'd0) begin
              d_state_d = D_DATA;
              rd_load_s = 1'b1;
              rd_idx_s  = mHADDR[9:2];
            end else begin
              d_state_d = D_WAIT;
              wcnt_d    = WS_LOAD;
            end
          end
        end else begin
          d_state_d = D_IDLE;
        end
      end
      D_WAIT: begin
        if (wcnt_q == 4'd0) begin
          d_state_d = D_DATA;
          rd_load_s = 1'b1;
        end else begin
          wcnt_d = wcnt_q - 4'd1;
        end
      end
      D_ERR1:  d_state_d = D_ERR2;
      D_ERR2:  d_state_d = D_IDLE;
      default: d_state_d = D_IDLE;
    endcase
  end

  // Bus handshake outputs are decoded from the next state so they leave a flop.
  always_comb begin
    ready_d = 1'b1;
    resp_d  = HRESP_OKAY;
    case (d_state_d)
      D_WAIT: begin
        ready_d = 1'b0;
        resp_d  = HRESP_OKAY;
      end
      D_ERR1: begin
        ready_d = 1'b0;
        resp_d  = HRESP_ERR;
      end
      D_ERR2: begin
        ready_d = 1'b1;
        resp_d  = HRESP_ERR;
      end
      default: begin
        ready_d = 1'b1;
        resp_d  = HRESP_OKAY;
      end
    endcase
  end

  // State and output registers; reset aborts any transfer in flight.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      g_state_q <= G_IDLE;
      d_state_q <= D_IDLE;
      wcnt_q    <= 4'd0;
      idx_q     <= 8'd0;
      prev_q    <= 32'd0;
      ready_q   <= 1'b1;
      resp_q    <= HRESP_OKAY;
      rdata_q   <= 32'd0;
    end else begin
      g_state_q <= g_state_d;
      d_state_q <= d_state_d;
      wcnt_q    <= wcnt_d;
      idx_q     <= idx_d;
      prev_q    <= prev_d;
      ready_q   <= ready_d;
      resp_q    <= resp_d;
      if (rd_load_s) begin
        rdata_q <= mem_q[rd_idx_s];
      end
    end
  end

  // Backdoor preload; the read above samples the pre-edge contents, giving read-before-write.
  always_ff @(posedge HCLK) begin
    if (ld_we && !HRESET) begin
      mem_q[ld_addr] <= ld_data;
    end
  end

endmodule

// File: tb/tb_ahb_mem_responder.sv
// Bench for ahb_mem_responder: three instances (0, 1 and 3 wait states) share one stimulus;
// directed vector table and sequences, then random traffic against a scheduled-response model.
module tb_ahb_mem_responder;

  logic        HCLK;
  logic        HRESET;
  logic        mHBUSREQ;
  logic [1:0]  mHTRANS;
  logic [31:0] mHADDR;
  logic        mHWRITE;
  logic [2:0]  mHSIZE;
  logic [2:0]  mHBURST;
  logic        ld_we;
  logic [7:0]  ld_addr;
  logic [31:0] ld_data;

  logic        gnt  [3];
  logic        rdy  [3];
  logic [1:0]  resp [3];
  logic [31:0] rd   [3];

  int vectors    = 0;
  int miscompares = 0;

  ahb_mem_responder #(.WAIT_STATES(0), .BASE(32'h0000_0000)) u_ws0 (
    .HCLK(HCLK), .HRESET(HRESET), .mHBUSREQ(mHBUSREQ), .mHGRANT(gnt[0]),
    .mHTRANS(mHTRANS), .mHADDR(mHADDR), .mHWRITE(mHWRITE), .mHSIZE(mHSIZE),
    .mHBURST(mHBURST), .mHREADY(rdy[0]), .mHRESP(resp[0]), .mHRDATA(rd[0]),
    .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data));

  ahb_mem_responder #(.WAIT_STATES(1), .BASE(32'h0000_0000)) u_ws1 (
    .HCLK(HCLK), .HRESET(HRESET), .mHBUSREQ(mHBUSREQ), .mHGRANT(gnt[1]),
    .mHTRANS(mHTRANS), .mHADDR(mHADDR), .mHWRITE(mHWRITE), .mHSIZE(mHSIZE),
    .mHBURST(mHBURST), .mHREADY(rdy[1]), .mHRESP(resp[1]), .mHRDATA(rd[1]),
    .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data));

  ahb_mem_responder #(.WAIT_STATES(3), .BASE(32'h0000_0000)) u_ws3 (
    .HCLK(HCLK), .HRESET(HRESET), .mHBUSREQ(mHBUSREQ), .mHGRANT(gnt[2]),
    .mHTRANS(mHTRANS), .mHADDR(mHADDR), .mHWRITE(mHWRITE), .mHSIZE(mHSIZE),
    .mHBURST(mHBURST), .mHREADY(rdy[2]), .mHRESP(resp[2]), .mHRDATA(rd[2]),
    .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data));

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  // Reference model: each accepted transfer schedules its future response cycles in a queue.
  typedef struct packed {
    logic       ready;
    logic       err;
    logic       beat;
    logic [7:0] idx;
  } slot_t;

  typedef struct {
    logic        wr;
    logic [2:0]  sz;
    logic [31:0] addr;
    logic        err;
    logic [31:0] data;
  } vec_t;

  int          mws [3] = '{0, 1, 3};
  slot_t       mq  [3][$];
  logic        mgnt  [3];
  logic [31:0] mprev [3];
  logic [31:0] mrd   [3];
  logic [31:0] smem  [256];
  bit          model_on = 1'b0;

  function automatic slot_t mk(logic r, logic e, logic b, logic [7:0] idx);
    slot_t s;
    s.ready = r;
    s.err   = e;
    s.beat  = b;
    s.idx   = idx;
    return s;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic model_step();
    for (int i = 0; i < 3; i++) begin
      slot_t cur;
      logic  idle;
      logic  take;
      logic  bad;
      idle = (mq[i].size() == 0);
      cur  = idle ? mk(1'b1, 1'b0, 1'b0, 8'd0) : mq[i][0];
      take = mgnt[i] && cur.ready && !cur.err && mHTRANS[1];
      bad  = mHWRITE || (mHSIZE != 3'b010) || (mHADDR[1:0] != 2'b00) ||
             (mHADDR[31:10] != 22'd0) ||
             ((mHTRANS == 2'b11) && (mHADDR != mprev[i] + 32'd4));
      if (!idle) void'(mq[i].pop_front());
      if (take) begin
        if (bad) begin
          mq[i].push_back(mk(1'b0, 1'b1, 1'b0, 8'd0));
          mq[i].push_back(mk(1'b1, 1'b1, 1'b0, 8'd0));
        end else begin
          for (int w = 0; w < mws[i]; w++) mq[i].push_back(mk(1'b0, 1'b0, 1'b0, 8'd0));
          mq[i].push_back(mk(1'b1, 1'b0, 1'b1, mHADDR[9:2]));
          mprev[i] = mHADDR;
        end
      end
      if (mq[i].size() != 0 && mq[i][0].beat) mrd[i] = smem[mq[i][0].idx];
      mgnt[i] = mHBUSREQ || (mgnt[i] && !idle);
    end
    if (ld_we) smem[ld_addr] = ld_data;
  endtask

  task automatic model_check();
    for (int i = 0; i < 3; i++) begin
      slot_t cur;
      cur = (mq[i].size() == 0) ? mk(1'b1, 1'b0, 1'b0, 8'd0) : mq[i][0];
      chk($sformatf("rand ws%0d grant", mws[i]), 32'(gnt[i]), 32'(mgnt[i]));
      chk($sformatf("rand ws%0d ready", mws[i]), 32'(rdy[i]), 32'(cur.ready));
      chk($sformatf("rand ws%0d resp", mws[i]), 32'(resp[i]), 32'(cur.err));
      chk($sformatf("rand ws%0d rdata", mws[i]), rd[i], mrd[i]);
    end
  endtask

  task automatic tick();
    if (model_on) model_step();
    @(posedge HCLK);
    #1;
    if (model_on) model_check();
  endtask

  task automatic bus(input logic [1:0] t, input logic [31:0] a);
    mHTRANS = t;
    mHADDR  = a;
    mHWRITE = 1'b0;
    mHSIZE  = 3'b010;
  endtask

  task automatic preload(input logic [7:0] a, input logic [31:0] d);
    ld_we   = 1'b1;
    ld_addr = a;
    ld_data = d;
    smem[a] = d;
    tick();
    ld_we   = 1'b0;
  endtask

  vec_t        tab [6];
  logic [31:0] last_data;
  logic [31:0] mlast;
  int          r;

  initial begin
    tab[0] = '{1'b0, 3'b010, 32'h0000_0014, 1'b0, 32'hA5A5_0005};
    tab[1] = '{1'b1, 3'b010, 32'h0000_0014, 1'b1, 32'h0000_0000};
    tab[2] = '{1'b0, 3'b000, 32'h0000_0014, 1'b1, 32'h0000_0000};
    tab[3] = '{1'b0, 3'b010, 32'h0000_0400, 1'b1, 32'h0000_0000};
    tab[4] = '{1'b0, 3'b010, 32'h0000_0016, 1'b1, 32'h0000_0000};
    tab[5] = '{1'b0, 3'b010, 32'h0000_0018, 1'b0, 32'h0000_0066};

    HRESET = 1'b1; mHBUSREQ = 1'b0; mHBURST = 3'b000;
    ld_we = 1'b0; ld_addr = 8'd0; ld_data = 32'd0;
    bus(2'b00, 32'd0);
    tick(); tick();
    chk("reset grant", 32'(gnt[1]), 32'd0);
    chk("reset ready", 32'(rdy[1]), 32'd1);
    chk("reset resp", 32'(resp[1]), 32'd0);
    chk("reset rdata", rd[1], 32'd0);
    HRESET = 1'b0;
    tick();

    preload(8'd0, 32'd0); preload(8'd1, 32'd1); preload(8'd2, 32'd2); preload(8'd3, 32'd3);
    preload(8'd4, 32'h0000_0044); preload(8'd5, 32'hA5A5_0005);
    preload(8'd6, 32'h0000_0066); preload(8'd9, 32'h1111_1111);

    // Grant handover: request for three cycles, then drop while idle.
    mHBUSREQ = 1'b1;
    chk("handover before", 32'(gnt[1]), 32'd0);
    tick(); chk("handover rise", 32'(gnt[1]), 32'd1);
    tick(); chk("handover hold1", 32'(gnt[1]), 32'd1);
    tick(); chk("handover hold2", 32'(gnt[1]), 32'd1);
    mHBUSREQ = 1'b0;
    tick(); chk("handover fall", 32'(gnt[1]), 32'd0);
    mHBUSREQ = 1'b1;
    tick();

    // Single NONSEQ transfers on the one-wait-state instance.
    last_data = 32'd0;
    for (int v = 0; v < 6; v++) begin
      mHTRANS = 2'b10; mHADDR = tab[v].addr; mHWRITE = tab[v].wr; mHSIZE = tab[v].sz;
      tick();
      bus(2'b00, 32'd0);
      chk($sformatf("tab%0d c1 ready", v), 32'(rdy[1]), 32'd0);
      chk($sformatf("tab%0d c1 resp", v), 32'(resp[1]), tab[v].err ? 32'd1 : 32'd0);
      tick();
      if (!tab[v].err) last_data = tab[v].data;
      chk($sformatf("tab%0d c2 ready", v), 32'(rdy[1]), 32'd1);
      chk($sformatf("tab%0d c2 resp", v), 32'(resp[1]), tab[v].err ? 32'd1 : 32'd0);
      chk($sformatf("tab%0d c2 rdata", v), rd[1], last_data);
      tick();
      chk($sformatf("tab%0d c3 ready", v), 32'(rdy[1]), 32'd1);
      chk($sformatf("tab%0d c3 resp", v), 32'(resp[1]), 32'd0);
    end
    repeat (5) tick();

    // INCR4 burst with zero wait states: four back-to-back beats.
    mHBURST = 3'b011;
    for (int b = 0; b < 4; b++) begin
      bus((b == 0) ? 2'b10 : 2'b11, 32'(b * 4));
      tick();
      chk($sformatf("incr4 beat%0d ready", b), 32'(rdy[0]), 32'd1);
      chk($sformatf("incr4 beat%0d resp", b), 32'(resp[0]), 32'd0);
      chk($sformatf("incr4 beat%0d rdata", b), rd[0], 32'(b));
    end
    mHBURST = 3'b000;
    bus(2'b00, 32'd0);
    tick();
    chk("incr4 end rdata", rd[0], 32'd3);

    // Broken burst, then an address phase offered during the ERROR tail is ignored.
    bus(2'b10, 32'h10); tick();
    chk("broken beat1 ready", 32'(rdy[0]), 32'd1);
    chk("broken beat1 rdata", rd[0], 32'h44);
    bus(2'b11, 32'h18); tick();
    chk("broken err1 ready", 32'(rdy[0]), 32'd0);
    chk("broken err1 resp", 32'(resp[0]), 32'd1);
    bus(2'b00, 32'd0); tick();
    chk("broken err2 ready", 32'(rdy[0]), 32'd1);
    chk("broken err2 resp", 32'(resp[0]), 32'd1);
    bus(2'b10, 32'h14); tick();
    chk("err2 ignore resp", 32'(resp[0]), 32'd0);
    bus(2'b00, 32'd0); tick();
    chk("err2 ignore ready", 32'(rdy[0]), 32'd1);
    chk("err2 ignore rdata", rd[0], 32'h44);

    // Backdoor write to the word being returned in its data cycle.
    bus(2'b10, 32'h18); tick();
    chk("rbw beat rdata", rd[0], 32'h66);
    bus(2'b00, 32'd0);
    ld_we = 1'b1; ld_addr = 8'd6; ld_data = 32'h6666_0000; smem[6] = 32'h6666_0000;
    tick();
    ld_we = 1'b0;
    chk("rbw hold rdata", rd[0], 32'h66);
    bus(2'b10, 32'h18); tick();
    chk("rbw reread rdata", rd[0], 32'h6666_0000);
    bus(2'b00, 32'd0); tick();

    // Backdoor write attempted under reset must not land.
    HRESET = 1'b1; ld_we = 1'b1; ld_addr = 8'd9; ld_data = 32'hDEAD_BEEF;
    tick();
    ld_we = 1'b0;
    chk("rst2 grant", 32'(gnt[0]), 32'd0);
    chk("rst2 rdata", rd[0], 32'd0);
    HRESET = 1'b0;
    tick();
    chk("regrant", 32'(gnt[0]), 32'd1);
    bus(2'b10, 32'h24); tick();
    bus(2'b00, 32'd0);
    chk("ld under reset ignored", rd[0], 32'h1111_1111);
    repeat (5) tick();
    chk("ws3 read rdata", rd[2], 32'h1111_1111);

    // Reset during the second wait cycle of the three-wait-state instance.
    bus(2'b10, 32'h14); tick();
    bus(2'b00, 32'd0);
    chk("ws3 wait1 ready", 32'(rdy[2]), 32'd0);
    tick();
    chk("ws3 wait2 ready", 32'(rdy[2]), 32'd0);
    #1 HRESET = 1'b1;
    #1;
    chk("async rst ready", 32'(rdy[2]), 32'd1);
    chk("async rst resp", 32'(resp[2]), 32'd0);
    chk("async rst rdata", rd[2], 32'd0);
    chk("async rst grant", 32'(gnt[2]), 32'd0);
    mHBUSREQ = 1'b0;
    tick();
    HRESET = 1'b0;
    tick(); chk("post rst grant a", 32'(gnt[2]), 32'd0);
    tick(); chk("post rst grant b", 32'(gnt[2]), 32'd0);
    mHBUSREQ = 1'b1;
    tick(); chk("post rst grant c", 32'(gnt[2]), 32'd1);
    repeat (5) tick();
    chk("post rst no beat", rd[2], 32'd0);

    // Random traffic against the model, starting from a fresh reset and a full preload.
    HRESET = 1'b1; mHBUSREQ = 1'b0; bus(2'b00, 32'd0);
    tick();
    HRESET = 1'b0;
    tick();
    for (int a = 0; a < 256; a++) preload(8'(a), $urandom);
    for (int i = 0; i < 3; i++) begin
      mq[i].delete();
      mgnt[i]  = 1'b0;
      mprev[i] = 32'd0;
      mrd[i]   = 32'd0;
    end
    mlast = 32'd0;
    model_on = 1'b1;
    for (int c = 0; c < 1500; c++) begin
      mHBUSREQ = ($urandom_range(0, 9) != 0);
      r = $urandom_range(0, 9);
      mHTRANS = (r < 2) ? 2'b00 : (r < 3) ? 2'b01 : (r < 6) ? 2'b10 : 2'b11;
      if (mHTRANS == 2'b11 && $urandom_range(0, 3) != 0) begin
        mHADDR = mlast + 32'd4;
      end else begin
        mHADDR = {22'd0, 8'($urandom), 2'b00};
        if ($urandom_range(0, 19) == 0) mHADDR = mHADDR ^ 32'h0000_0400;
        if ($urandom_range(0, 19) == 0) mHADDR = mHADDR | 32'h0000_0002;
      end
      if (mHTRANS[1]) mlast = mHADDR;
      mHWRITE = ($urandom_range(0, 19) == 0);
      mHSIZE  = ($urandom_range(0, 9) == 0) ? 3'b000 : 3'b010;
      mHBURST = 3'($urandom);
      ld_we   = ($urandom_range(0, 7) == 0);
      ld_addr = 8'($urandom);
      ld_data = $urandom;
      tick();
    end
    model_on = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ahb_mem_responder.md
AHB_MEM_RESPONDER -- requirements
Module: ahb_mem_responder

Interface
Parameters (name, default, meaning):
REQ-001 The block SHALL have parameter WAIT_STATES, default 1, giving the number of mHREADY-low cycles inserted before each read data beat (0..15).
REQ-002 The block SHALL have parameter BASE, default 32'h0000_0000, giving the 1 KB-aligned base address of the 256-word memory window.

Ports (name, direction, width, meaning):
REQ-003 HCLK  input  1  single clock; all logic is on its rising edge.
REQ-004 HRESET  input  1  asynchronous, active-high reset.
REQ-005 mHBUSREQ  input  1  bus request from the LCD DMA master.
REQ-006 mHGRANT  output  1  bus grant to the master.
REQ-007 mHTRANS  input  2  transfer type: 0 IDLE, 1 BUSY, 2 NONSEQ, 3 SEQ.
REQ-008 mHADDR  input  32  byte address.
REQ-009 mHWRITE  input  1  write flag; writes are not supported.
REQ-010 mHSIZE  input  3  transfer size; only 3'b010 (word) is legal.
REQ-011 mHBURST  input  3  burst type; informational only, with no effect on the response.
REQ-012 mHREADY  output  1  transfer done / wait-state control.
REQ-013 mHRESP  output  2  2'b00 OKAY, 2'b01 ERROR.
REQ-014 mHRDATA  output  32  read data.
REQ-015 ld_we, ld_addr[7:0], ld_data[31:0]  input  backdoor memory preload for the testbench/host.

Function
REQ-016 Grant FSM, states G_IDLE and G_OWN.
- G_IDLE -> G_OWN on the edge where mHBUSREQ=1; mHGRANT=1 from the next cycle.
- G_OWN -> G_IDLE on the first edge where mHBUSREQ=0 and the data FSM is in D_IDLE.
REQ-017 Address phase: sampled on an edge where mHREADY=1 and mHGRANT=1.
- Only mHTRANS = NONSEQ or SEQ starts a data phase.
- IDLE or BUSY gives a zero-wait OKAY with mHREADY=1.
REQ-018 Error check, evaluated at address-phase sampling. A transfer is an error if any of the following holds:
- mHWRITE=1;
- mHSIZE != 3'b010;
- mHADDR[1:0] != 0;
- mHADDR[31:10] != BASE[31:10];
- mHTRANS=SEQ and mHADDR != previous accepted address + 4 (32-bit wrap).
REQ-019 Data FSM states: D_IDLE, D_WAIT, D_DATA, D_ERR1, D_ERR2.
REQ-020 Legal read, WAIT_STATES > 0:
- D_WAIT for WAIT_STATES cycles with mHREADY=0 and mHRESP=00;
- then one D_DATA cycle with mHREADY=1, mHRESP=00, mHRDATA=mem[addr[9:2]].
REQ-021 Legal read, WAIT_STATES = 0: D_DATA directly, so the data beat comes one cycle after the address phase.
REQ-022 A new address phase presented during the D_DATA cycle SHALL be accepted (pipelined), so back-to-back beats need no idle cycle between them.
REQ-023 Error transfer:
- D_ERR1: mHREADY=0, mHRESP=01;
- D_ERR2: mHREADY=1, mHRESP=01;
- an address phase presented in D_ERR2 SHALL be ignored, with the FSM returning to D_IDLE.
REQ-024 mHRDATA SHALL hold its last value outside D_DATA.
REQ-025 Memory: 256 x 32 bits, with no reset of its contents.
REQ-026 Backdoor write: when ld_we=1, mem[ld_addr] <= ld_data on the next edge.
REQ-027 A backdoor write to the same address in the D_DATA cycle returns the old data (read-before-write).
REQ-028 The previous-address register SHALL update only on accepted, error-free NONSEQ/SEQ transfers.
REQ-029 mHGRANT deassertion mid-burst: the current data phase SHALL complete normally, and no new address phase is accepted while mHGRANT=0.

Reset
REQ-030 While HRESET=1, the outputs SHALL be:
- mHGRANT=0, mHREADY=1, mHRESP=00, mHRDATA=0;
- both FSMs in their idle states;
- wait counter 0;
- previous-address register 0.
REQ-031 Reset asserted mid-transfer SHALL abort the transfer immediately (asynchronously), with no beat completed.
REQ-032 ld_we SHALL be ignored while HRESET=1.

Verification
REQ-033 Single read: preload mem[5]=32'hA5A5_0005, WAIT_STATES=1, mHBUSREQ=1, then NONSEQ at BASE+0x14 -> one cycle with mHREADY=0, then mHREADY=1, mHRESP=00, mHRDATA=32'hA5A5_0005.
REQ-034 INCR4 burst: words 0..3 preloaded with 0..3, WAIT_STATES=0, NONSEQ 0x0 then SEQ 0x4, 0x8, 0xC -> four consecutive mHREADY=1 beats returning 0,1,2,3.
REQ-035 Error: write, or mHSIZE=3'b000, or address BASE+0x400 -> mHREADY=0/RESP=01, then mHREADY=1/RESP=01, then idle OKAY.
REQ-036 Broken burst: NONSEQ 0x10 then SEQ 0x18 -> first beat OKAY, second beat two-cycle ERROR.
REQ-037 Reset mid-wait: WAIT_STATES=3, HRESET asserted during the 2nd wait cycle -> outputs at reset values immediately; after release, mHGRANT=0 until mHBUSREQ is sampled.
REQ-038 Grant handover: mHBUSREQ=1 for 3 cycles then 0 while idle -> mHGRANT rises one cycle after the request and falls one cycle after the request drops.
